// File: rtl/rs_issue_latch.sv
// rs_issue_latch: two-lane issue pipeline register behind the RS two-stage
// priority selector. Lane 0 captures the stage-1 grant and lane 1 captures
// the stage-2 grant. Each lane holds its entry while its FU back-pressures.
// slot_clr tells the RS which slots really left this cycle.
//
// Handshake (both lanes, FU side): iss_valid[i] is the valid and fu_ready[i]
// is the ready. An entry transfers on a cycle where both are high. While
// valid is high and ready is low, iss_func/iss_pkt/iss_idx stay frozen. A lane
// may take a new grant in the same cycle its current entry transfers.
// Grant side: a grant is taken only in the cycle its slot_clr bit is high.
// Otherwise the slot stays in the RS and is simply reselected later.

package rs_issue_pkg;
    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_LSU = 2'd2,
        FU_BR  = 2'd3
    } func_unit_t;
endpackage

module rs_issue_latch
    import rs_issue_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int PKT_W = 64,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int FU_W  = $bits(func_unit_t)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             gnt_0,
    input  logic [WIDTH-1:0]             gnt_1,
    input  func_unit_t                   func_0,
    input  func_unit_t                   func_1,
    input  logic [WIDTH-1:0][PKT_W-1:0]  slot_pkt,
    input  logic [1:0]                   fu_ready,
    output logic [1:0]                   iss_valid,
    output func_unit_t [1:0]             iss_func,
    output logic [1:0][PKT_W-1:0]        iss_pkt,
    output logic [1:0][IDX_W-1:0]        iss_idx,
    output logic [WIDTH-1:0]             slot_clr,
    output logic [1:0]                   lane_stall,
    // Diagnostic: the grants overlap, or a grant has more than one bit set.
    output logic                         grant_err
);

    // One-hot to binary by OR reduction. A multi-hot input gives an
    // undefined index and is reported on grant_err.
    function automatic logic [IDX_W-1:0] enc(input logic [WIDTH-1:0] g);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (g[i]) r = r | i[IDX_W-1:0];
        end
        return r;
    endfunction

    function automatic logic multi_hot(input logic [WIDTH-1:0] g);
        return (g & (g - WIDTH'(1))) != '0;
    endfunction

    logic [1:0]                   valid_q, valid_d;
    logic [1:0][FU_W-1:0]         func_q,  func_d;
    logic [1:0][PKT_W-1:0]        pkt_q,   pkt_d;
    logic [1:0][IDX_W-1:0]        idx_q,   idx_d;

    logic [1:0][WIDTH-1:0]        gnt;
    logic [1:0][FU_W-1:0]         func_in;
    logic [1:0][IDX_W-1:0]        gnt_idx;
    logic [1:0]                   ld;
    logic [1:0]                   req;
    logic [1:0]                   acc;
    logic [1:0]                   fire;
    logic                         overlap;

    // Grant qualification, accept/fire decisions and the combinational
    // outputs to the RS and the FUs.
    always_comb begin
        gnt[0]     = gnt_0;
        gnt[1]     = gnt_1;
        func_in[0] = func_0;
        func_in[1] = func_1;
        gnt_idx[0] = enc(gnt_0);
        gnt_idx[1] = enc(gnt_1);

        overlap    = (gnt_0 & gnt_1) != '0;
        grant_err  = overlap | multi_hot(gnt_0) | multi_hot(gnt_1);

        // A lane can load when it is empty or when its entry leaves this cycle.
        ld         = ~valid_q | fu_ready;
        req[0]     = |gnt_0;
        // Stage 1 wins a shared slot. Lane 1 drops its grant in that case.
        req[1]     = (|gnt_1) & ~overlap;
        acc        = req & ld & {2{~flush & ~reset}};
        fire       = valid_q & fu_ready;

        slot_clr   = (acc[0] ? gnt_0 : '0) | (acc[1] ? gnt_1 : '0);
        lane_stall = valid_q & ~fu_ready & {2{~reset}};
    end

    // Next lane contents. Flush clears both lanes, a load beats a drain,
    // and otherwise the payload holds.
    always_comb begin
        valid_d = valid_q;
        func_d  = func_q;
        pkt_d   = pkt_q;
        idx_d   = idx_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    valid_d[i] = 1'b1;
                    func_d[i]  = func_in[i];
                    pkt_d[i]   = slot_pkt[gnt_idx[i]];
                    idx_d[i]   = gnt_idx[i];
                end else if (fire[i]) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    // Lane registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            func_q  <= '0;
            pkt_q   <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            func_q  <= func_d;
            pkt_q   <= pkt_d;
            idx_q   <= idx_d;
        end
    end

    assign iss_valid   = valid_q;
    assign iss_func[0] = func_unit_t'(func_q[0]);
    assign iss_func[1] = func_unit_t'(func_q[1]);
    assign iss_pkt     = pkt_q;
    assign iss_idx     = idx_q;

endmodule
